lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//  Receive-side companion to the LFSR pattern generator.
//  - Accepts the generator's N-bit output words and self-synchronises to the sequence.
//  - Once locked, predicts each following word and flags mismatches.
//  - Counts errors and detects loss of sync; reports full-period completion.
//  - Sits at the far end of a test data path: generator -> DUT/link -> checker.
// PARAMETERS
//  N         4  word / LFSR width, legal 2..8
//  LOCK_CNT  4  consecutive predicted matches required to declare lock, >=1
//  LOSS_CNT  3  consecutive mismatches while locked that drop lock, >=1
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high reset
//  in_valid      in   1   in_data carries a sequence word this cycle
//  in_data       in   N   received LFSR word
//  clear_err     in   1   synchronous clear of err_count
//  locked        out  1   checker is locked to the sequence
//  err_pulse     out  1   one-cycle strobe: last locked word mismatched
//  err_count     out  16  mismatches seen while locked, saturates at 16'hFFFF
//  period_pulse  out  1   one-cycle strobe: 2^N-1 words checked since lock or last strobe
// BEHAVIOUR
//  - Step function nxt(x) = {x[N-2:0], ^(x & TAP)}. Fibonacci form, shift left, feedback into LSB.
//  - TAP by N:
//      2: 'b11        3: 'b110       4: 'b1100       5: 'b10100
//      6: 'b110000    7: 'b1100000   8: 'b10111000
//  - Registers: exp[N-1:0], match_cnt, miss_cnt, word_cnt (mod 2^N-1), state.
//  - All outputs are registered; each is updated on the edge that samples the word.
//  - Reset: state=SYNC; exp, match_cnt, miss_cnt, word_cnt = 0.
//  - Reset: locked=0, err_pulse=0, err_count=0, period_pulse=0.
//  - Reset mid-operation: same values on the next edge; takes priority over every other input.
//  - in_valid=0: no state, counter or exp change. err_pulse and period_pulse read 0.
//  - State SYNC (locked=0):
//      valid, in_data!=0 -> exp<=nxt(in_data), match_cnt<=0, go CHECK.
//      valid, in_data==0 -> stay SYNC (all-zero word is the lockup state, never a seed).
//  - State CHECK (locked=0):
//      valid, in_data==exp -> exp<=nxt(exp), match_cnt++.
//          If match_cnt==LOCK_CNT-1 -> go LOCKED, locked<=1, word_cnt<=0, miss_cnt<=0.
//      valid, mismatch, in_data!=0 -> reseed: exp<=nxt(in_data), match_cnt<=0, stay CHECK.
//      valid, mismatch, in_data==0 -> go SYNC.
//      No errors are counted outside LOCKED.
//  - State LOCKED (locked=1):
//      valid -> exp<=nxt(exp) always. Prediction never reseeds from input, so errors do not propagate.
//      match -> miss_cnt<=0.
//      mismatch -> err_pulse<=1, err_count saturating +1, miss_cnt++.
//          If miss_cnt==LOSS_CNT-1 -> go SYNC, locked<=0 on the same edge.
//      word_cnt increments per valid word. At 2^N-2 it wraps to 0 and period_pulse<=1.
//  - clear_err=1: err_count<=0. Wins over a coincident increment; err_pulse still fires.
//  - Latency: one clock from the sampling edge of a word to its err_pulse / locked update.
//  - Lock takes 1 seed word + LOCK_CNT matching words.
// TESTING (N=4, LOCK_CNT=4, LOSS_CNT=3)
//  Sequence from seed 0001:
//    0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000 (then repeats).
//  1 Lock: reset, stream 0001,0010,0100,1001,0011 back-to-back.
//      -> locked=1 after the 5th word's edge, err_count=0.
//  2 Single error: after lock, send 0111 in place of 0110, then 1101.
//      -> err_pulse one cycle, err_count=1, locked stays 1, 1101 accepted as match.
//  3 Loss: after lock, send 3 consecutive wrong words.
//      -> err_count=3, locked=0 after 3rd; clean stream then re-locks in 5 words.
//  4 Lockup/reseed: in SYNC, feed 0000 x10 -> locked stays 0.
//      Feed 1000,1111,... (bad 2nd word) -> reseed from 1111; lock after 1111 + 4 matches.
//  5 Gaps/period: locked stream with random in_valid gaps -> zero errors.
//      period_pulse every 15 valid words; clear_err coincident with error -> err_count=0.
//  6 Reset mid-lock: assert reset for 1 cycle while locked with err_count=5.
//      -> all outputs 0 next edge; state SYNC.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for an N-bit Fibonacci LFSR pattern stream.
// Self-synchronises from a non-zero seed word, confirms lock after a run of
// correct predictions, then free-runs its own prediction and counts mismatches.
// Lock is dropped after a run of consecutive mismatches. A period strobe marks
// every 2^N-1 words checked while locked.

module lfsr_checker #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         clear_err,
    output logic         locked,
    output logic         err_pulse,
    output logic [15:0]  err_count,
    output logic         period_pulse
);

    // Feedback tap masks for maximal-length sequences, widths 2..8.
    function automatic logic [7:0] tap_sel(input int n);
        logic [7:0] t;
        case (n)
            2:       t = 8'b0000_0011;
            3:       t = 8'b0000_0110;
            4:       t = 8'b0000_1100;
            5:       t = 8'b0001_0100;
            6:       t = 8'b0011_0000;
            7:       t = 8'b0110_0000;
            8:       t = 8'b1011_1000;
            default: t = 8'b0000_0000;
        endcase
        return t;
    endfunction

    localparam logic [7:0]   TAP8 = tap_sel(N);
    localparam logic [N-1:0] TAP  = TAP8[N-1:0];
    localparam int           MW   = $clog2(LOCK_CNT + 1);
    localparam int           LW   = $clog2(LOSS_CNT + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);
    localparam logic [N-1:0]  WORD_LAST  = N'((2 ** N) - 2);

    // One LFSR step: shift left, parity of tapped bits enters the LSB.
    function automatic logic [N-1:0] nxt(input logic [N-1:0] x);
        return {x[N-2:0], ^(x & TAP)};
    endfunction

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_r;
    logic [N-1:0]  exp_r;
    logic [MW-1:0] match_cnt_r;
    logic [LW-1:0] miss_cnt_r;
    logic [N-1:0]  word_cnt_r;
    logic          err_inc_s;

    // A counted error is a valid word that disagrees with the locked prediction.
    always_comb begin
        err_inc_s = 1'b0;
        if (in_valid && (state_r == ST_LOCKED) && (in_data != exp_r)) begin
            err_inc_s = 1'b1;
        end else begin
            err_inc_s = 1'b0;
        end
    end

    // Sync/check/locked state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_SYNC;
            exp_r        <= {N{1'b0}};
            match_cnt_r  <= {MW{1'b0}};
            miss_cnt_r   <= {LW{1'b0}};
            word_cnt_r   <= {N{1'b0}};
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= 16'h0000;
            period_pulse <= 1'b0;
        end else begin
            err_pulse    <= 1'b0;
            period_pulse <= 1'b0;
            if (in_valid) begin
                case (state_r)
                    ST_SYNC: begin
                        // All-zero is the LFSR lockup word and can never seed.
                        if (in_data != {N{1'b0}}) begin
                            exp_r       <= nxt(in_data);
                            match_cnt_r <= {MW{1'b0}};
                            state_r     <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (in_data == exp_r) begin
                            exp_r       <= nxt(exp_r);
                            match_cnt_r <= match_cnt_r + MW'(1);
                            if (match_cnt_r == MATCH_LAST) begin
                                state_r    <= ST_LOCKED;
                                locked     <= 1'b1;
                                word_cnt_r <= {N{1'b0}};
                                miss_cnt_r <= {LW{1'b0}};
                            end
                        end else if (in_data != {N{1'b0}}) begin
                            exp_r       <= nxt(in_data);
                            match_cnt_r <= {MW{1'b0}};
                        end else begin
                            state_r <= ST_SYNC;
                        end
                    end
                    ST_LOCKED: begin
                        // Prediction free-runs so a corrupted word cannot poison later checks.
                        exp_r <= nxt(exp_r);
                        if (in_data == exp_r) begin
                            miss_cnt_r <= {LW{1'b0}};
                        end else begin
                            err_pulse  <= 1'b1;
                            miss_cnt_r <= miss_cnt_r + LW'(1);
                            if (miss_cnt_r == MISS_LAST) begin
                                state_r <= ST_SYNC;
                                locked  <= 1'b0;
                            end
                        end
                        if (word_cnt_r == WORD_LAST) begin
                            word_cnt_r   <= {N{1'b0}};
                            period_pulse <= 1'b1;
                        end else begin
                            word_cnt_r <= word_cnt_r + N'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_SYNC;
                        locked  <= 1'b0;
                    end
                endcase
            end
            // Clear wins over a coincident increment; the counter saturates.
            if (clear_err) begin
                err_count <= 16'h0000;
            end else if (err_inc_s && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (N=4, LOCK_CNT=4, LOSS_CNT=3).
// A table-driven reference model predicts the outputs of every cycle; the
// prediction is queued when the stimulus is applied and compared after the edge.

module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        clear_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        period_pulse;

    always #5 clk = ~clk;

    lfsr_checker #(.N(4), .LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear_err    (clear_err),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .period_pulse (period_pulse)
    );

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic        pp;
        logic [15:0] ec;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   per_seen = 0;
    int   gidx     = 0;

    logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                             4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                             4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // reference model state: 0 = SYNC, 1 = CHECK, 2 = LOCKED
    int          m_state;
    logic [3:0]  m_exp;
    int          m_match;
    int          m_miss;
    int          m_word;
    logic        m_lk;
    logic        m_ep;
    logic        m_pp;
    logic [15:0] m_ec;

    function automatic logic [3:0] succ(input logic [3:0] x);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            if (seq[i] == x) r = seq[(i + 1) % 15];
        end
        return r;
    endfunction

    function automatic logic [3:0] wrong(input logic [3:0] x);
        return (x == 4'b1010) ? 4'b0101 : 4'b1010;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_exp = 4'b0000; m_match = 0; m_miss = 0; m_word = 0;
        m_lk = 1'b0; m_ep = 1'b0; m_pp = 1'b0; m_ec = 16'h0000;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit clr);
        m_ep = 1'b0;
        m_pp = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 4'b0000) begin
                    m_exp = succ(d); m_match = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_exp = succ(m_exp);
                    m_match++;
                    if (m_match == 4) begin
                        m_state = 2; m_lk = 1'b1; m_word = 0; m_miss = 0;
                    end
                end else if (d != 4'b0000) begin
                    m_exp = succ(d); m_match = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (d == m_exp) begin
                    m_miss = 0;
                end else begin
                    m_ep = 1'b1;
                    if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                    m_miss++;
                    if (m_miss == 3) begin
                        m_state = 0; m_lk = 1'b0;
                    end
                end
                m_exp = succ(m_exp);
                m_word++;
                if (m_word == 15) begin
                    m_word = 0; m_pp = 1'b1;
                end
            end
        end
        if (clr) m_ec = 16'h0000;
    endtask

    task automatic compare_next();
        exp_t e;
        e = sb.pop_front();
        chk("locked", {15'd0, locked}, {15'd0, e.lk});
        chk("err_pulse", {15'd0, err_pulse}, {15'd0, e.ep});
        chk("period_pulse", {15'd0, period_pulse}, {15'd0, e.pp});
        chk("err_count", err_count, e.ec);
        if (period_pulse === 1'b1) per_seen++;
    endtask

    task automatic drive(input bit v, input logic [3:0] d, input bit clr);
        in_valid  = v;
        in_data   = d;
        clear_err = clr;
        model_step(v, d, clr);
        sb.push_back('{m_lk, m_ep, m_pp, m_ec});
        @(posedge clk);
        #1;
        compare_next();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0; in_data = 4'b0000; clear_err = 1'b0;
        model_reset();
        sb.push_back('{1'b0, 1'b0, 1'b0, 16'h0000});
        @(posedge clk);
        #1;
        compare_next();
        reset = 1'b0;
    endtask

    task automatic send_good();
        drive(1'b1, seq[gidx], 1'b0);
        gidx = (gidx + 1) % 15;
    endtask

    task automatic send_bad(input bit clr);
        drive(1'b1, wrong(seq[gidx]), clr);
        gidx = (gidx + 1) % 15;
    endtask

    initial begin
        // 1: lock from reset in exactly five words
        do_reset();
        gidx = 0;
        for (int i = 0; i < 4; i++) send_good();
        chk("t1_not_locked_after_4", {15'd0, locked}, 16'd0);
        send_good();
        chk("t1_locked_after_5", {15'd0, locked}, 16'd1);
        chk("t1_err_count", err_count, 16'd0);

        // 2: single corrupted word, then the next correct word still matches
        drive(1'b1, 4'b0111, 1'b0);
        gidx = (gidx + 1) % 15;
        chk("t2_err_pulse", {15'd0, err_pulse}, 16'd1);
        send_good();
        chk("t2_err_pulse_clear", {15'd0, err_pulse}, 16'd0);
        chk("t2_err_count", err_count, 16'd1);
        chk("t2_still_locked", {15'd0, locked}, 16'd1);

        // 3: three consecutive errors drop lock, clean stream relocks in 5 words
        do_reset();
        gidx = 3;
        for (int i = 0; i < 5; i++) send_good();
        for (int i = 0; i < 2; i++) send_bad(1'b0);
        chk("t3_locked_after_2_bad", {15'd0, locked}, 16'd1);
        send_bad(1'b0);
        chk("t3_unlocked", {15'd0, locked}, 16'd0);
        chk("t3_err_count", err_count, 16'd3);
        for (int i = 0; i < 4; i++) send_good();
        chk("t3_relock_pending", {15'd0, locked}, 16'd0);
        send_good();
        chk("t3_relocked", {15'd0, locked}, 16'd1);

        // 4: zero words never seed; a bad second word reseeds the prediction
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 4'b0000, 1'b0);
        chk("t4_zero_no_lock", {15'd0, locked}, 16'd0);
        drive(1'b1, 4'b1000, 1'b0);
        drive(1'b1, 4'b1111, 1'b0);
        gidx = 12;
        for (int i = 0; i < 3; i++) send_good();
        chk("t4_not_yet", {15'd0, locked}, 16'd0);
        send_good();
        chk("t4_locked_after_reseed", {15'd0, locked}, 16'd1);

        // 5: random gaps while locked, period strobe every 15 valid words
        per_seen = 0;
        for (int i = 0; i < 45; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) drive(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            send_good();
        end
        chk("t5_period_pulses", per_seen[15:0], 16'd3);
        chk("t5_no_errors", err_count, 16'd0);
        send_bad(1'b0);
        send_bad(1'b1);
        chk("t5_clr_err_pulse", {15'd0, err_pulse}, 16'd1);
        chk("t5_clr_err_count", err_count, 16'd0);
        send_good();

        // 6: reset while locked with errors recorded
        for (int i = 0; i < 5; i++) begin
            send_bad(1'b0);
            send_good();
        end
        chk("t6_err_count_5", err_count, 16'd5);
        chk("t6_locked_before", {15'd0, locked}, 16'd1);
        do_reset();
        chk("t6_locked_zero", {15'd0, locked}, 16'd0);
        chk("t6_err_count_zero", err_count, 16'd0);
        for (int i = 0; i < 4; i++) send_good();
        chk("t6_resync_pending", {15'd0, locked}, 16'd0);
        send_good();
        chk("t6_resynced", {15'd0, locked}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
